alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/alu_core.sv | 36 +++
 rtl/alu_sequencer.sv | 99 +++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, width and FSM state definitions
// for the ALU sequencer slice.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_AND = 4'd0;
    localparam logic [OP_W-1:0] OP_OR  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL = 4'd4;
    localparam logic [OP_W-1:0] OP_SRL = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command/response valid-ready bundle.
// master drives commands and consumes responses.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational 32-bit ALU.
// Illegal opcodes yield zero with err set.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (1'b1)
            (op == OP_AND): result = a & b;
            (op == OP_OR):  result = a | b;
            (op == OP_ADD): result = a + b;
            (op == OP_XOR): result = a ^ b;
            (op == OP_SLL): result = a << shamt;
            (op == OP_SRL): result = a >> shamt;
            (op == OP_SUB): result = a - b;
            (op == OP_SRA): result = $signed(a) >>> shamt;
            default:        err    = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/RESP sequencer around alu_core
// with registered handshake outputs and a completion counter.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t            state;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;
    logic              alu_err;

    logic              ready_r;
    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic              zero_r;
    logic              err_r;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    alu_core u_core (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (alu_res),
        .zero   (alu_zero),
        .err    (alu_err)
    );

    // All outputs are registered alongside the state, so cmd_ready
    // never depends combinationally on cmd_valid or rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            data_r   <= '0;
            zero_r   <= 1'b1;
            err_r    <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_r    <= bus.cmd_op;
                        a_r     <= bus.cmd_a;
                        b_r     <= bus.cmd_b;
                        ready_r <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    data_r  <= alu_res;
                    zero_r  <= alu_zero;
                    err_r   <= alu_err;
                    valid_r <= 1'b1;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        valid_r  <= 1'b0;
                        ready_r  <= 1'b1;
                        busy     <= 1'b0;
                        op_count <= op_count + CNT_ONE;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_data  = data_r;
    assign bus.rsp_zero  = zero_r;
    assign bus.rsp_err   = err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors plus a queue-based
// scoreboard checked on every falling edge.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    alu_sequencer_if bus();

    alu_sequencer #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        e;
    } rsp_t;

    int   errors = 0;
    int   checks = 0;
    rsp_t q[$];
    int   age = 0;
    int   acc = 0;
    int   done = 0;
    rsp_t front;
    logic exp_valid;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference results from the opcode table; SRA built from SRL plus sign fill.
    function automatic rsp_t golden(input logic [3:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        rsp_t        r;
        int          sh;
        logic [31:0] v;
        logic [31:0] ones;
        logic        e;
        sh   = int'(b[4:0]);
        ones = 32'hFFFF_FFFF;
        e    = 1'b0;
        case (op)
            4'd0: v = a & b;
            4'd1: v = a | b;
            4'd2: v = a + b;
            4'd3: v = a ^ b;
            4'd4: v = a << sh;
            4'd5: v = a >> sh;
            4'd6: v = a + (~b) + 32'd1;
            4'd7: v = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
            default: begin
                v = 32'h0;
                e = 1'b1;
            end
        endcase
        r.d = v;
        r.z = (v == 32'h0);
        r.e = e;
        return r;
    endfunction

    // Scoreboard: outstanding command count, edges since acceptance, completions.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            age  = 0;
            acc  = 0;
            done = 0;
            check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
            check("rst_rsp_data", bus.rsp_data, 32'd0);
            check("rst_rsp_zero", {31'b0, bus.rsp_zero}, 32'd1);
            check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_op_count", {16'b0, op_count}, 32'd0);
        end else begin
            exp_valid = (q.size() != 0) && (age >= 1);
            check("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, q.size() == 0});
            check("busy", {31'b0, busy}, {31'b0, q.size() != 0});
            check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_valid});
            check("op_count", {16'b0, op_count}, done & 32'hFFFF);
            if (exp_valid) begin
                front = q[0];
                check("rsp_data", bus.rsp_data, front.d);
                check("rsp_zero", {31'b0, bus.rsp_zero}, {31'b0, front.z});
                check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, front.e});
            end
            if (q.size() == 0) begin
                if (bus.cmd_valid) begin
                    q.push_back(golden(bus.cmd_op, bus.cmd_a, bus.cmd_b));
                    age = 0;
                    acc++;
                end
            end else if (age >= 1 && bus.rsp_ready) begin
                void'(q.pop_front());
                done++;
            end else begin
                age++;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall,
                         input bit inject, output rsp_t got,
                         output int lat);
        int n;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {bus.rsp_data, bus.rsp_zero, bus.rsp_err};
        if (inject) begin
            bus.cmd_op    = OP_ADD;
            bus.cmd_a     = 32'd1;
            bus.cmd_b     = 32'd1;
            bus.cmd_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
            check("stall_rsp_data", bus.rsp_data, got.d);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    rsp_t r;
    int   lat;
    int   cnt0;
    int   cyc;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = 32'd0;
        bus.cmd_b     = 32'd0;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, r, lat);
        check("add_latency_edge", lat, 32'd2);
        check("add_data", r.d, 32'h0);
        check("add_zero", {31'b0, r.z}, 32'd1);
        check("add_err", {31'b0, r.e}, 32'd0);
        check("add_op_count", {16'b0, op_count}, 32'd1);

        issue(OP_SRA, 32'h8000_0000, 32'h0000_0024, 0, 1'b0, r, lat);
        check("sra_data", r.d, 32'hF800_0000);
        issue(OP_SRL, 32'h8000_0000, 32'h0000_0024, 0, 1'b0, r, lat);
        check("srl_data", r.d, 32'h0800_0000);
        issue(OP_SLL, 32'h0000_0001, 32'hFFFF_FFE1, 0, 1'b0, r, lat);
        check("sll_data", r.d, 32'h0000_0002);
        issue(OP_XOR, 32'h0000_1234, 32'h0000_FFFF, 1, 1'b0, r, lat);
        check("xor_data", r.d, 32'h0000_EDCB);
        issue(OP_OR, 32'h0F00_0000, 32'h0000_00F0, 0, 1'b0, r, lat);
        check("or_data", r.d, 32'h0F00_00F0);

        issue(OP_SUB, 32'd5, 32'd7, 5, 1'b1, r, lat);
        check("sub_data", r.d, 32'hFFFF_FFFE);
        check("sub_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("sub_idle_busy", {31'b0, busy}, 32'd0);

        cnt0 = int'(op_count);
        issue(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, r, lat);
        check("ill_data", r.d, 32'h0);
        check("ill_zero", {31'b0, r.z}, 32'd1);
        check("ill_err", {31'b0, r.e}, 32'd1);
        check("ill_count", {16'b0, op_count}, cnt0 + 1);

        // Abort an AND while it is in EXEC.
        bus.cmd_op    = OP_AND;
        bus.cmd_a     = 32'hF0F0_F0F0;
        bus.cmd_b     = 32'hFF00_FF00;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check("abort_op_count", {16'b0, op_count}, 32'd0);
        check("abort_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        bus.rsp_ready = 1'b0;

        cyc = 0;
        while (done < 200 && cyc < 20000) begin
            bus.cmd_valid = (acc < 200) && ($urandom_range(0, 1) == 1);
            bus.cmd_op    = 4'($urandom_range(0, 15));
            bus.cmd_a     = $urandom;
            bus.cmd_b     = ($urandom_range(0, 1) == 1) ? $urandom
                                                        : 32'($urandom_range(0, 40));
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("rand_done", done, 32'd200);
        check("rand_op_count", {16'b0, op_count}, 32'd200);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
